// File: rtl/exec_cc_unit.sv
// Y86 execute-stage tail: condition-code register, branch/cmov condition
// evaluation, cmov destination cancel and the E->M pipeline register.
module exec_cc_unit #(
    parameter int         W        = 64,
    parameter logic [2:0] CC_RESET = 3'b100,
    parameter logic [3:0] RNONE    = 4'hF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   E_icode,
    input  logic [3:0]   E_ifun,
    input  logic [W-1:0] alu_valE,
    input  logic [2:0]   alu_cc,
    input  logic [W-1:0] E_valA,
    input  logic [3:0]   E_dstE,
    input  logic [3:0]   E_dstM,
    input  logic         m_stat_bad,
    input  logic         W_stat_bad,
    input  logic         M_stall,
    input  logic         M_bubble,
    output logic         e_cnd,
    output logic [3:0]   e_dstE,
    output logic [2:0]   cc_q,
    output logic [3:0]   M_icode,
    output logic         M_cnd,
    output logic [W-1:0] M_valE,
    output logic [W-1:0] M_valA,
    output logic [3:0]   M_dstE,
    output logic [3:0]   M_dstM
);

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;

    typedef enum logic [3:0] {
        C_YES = 4'h0,
        C_LE  = 4'h1,
        C_L   = 4'h2,
        C_E   = 4'h3,
        C_NE  = 4'h4,
        C_GE  = 4'h5,
        C_G   = 4'h6
    } cond_e;

    logic set_cc;
    logic zf, sf, of;
    logic cond;

    // An exception already further down the pipe must not let a younger OPq
    // change architectural flags.
    assign set_cc = (E_icode == I_OPQ) && !m_stat_bad && !W_stat_bad;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cc_q <= CC_RESET;
        end else if (set_cc) begin
            cc_q <= alu_cc;
        end
    end

    assign zf = cc_q[2];
    assign sf = cc_q[1];
    assign of = cc_q[0];

    // NOTE: the default assignment ahead of the case keeps reserved ifun
    // codes from leaving cond unassigned, which would infer a latch.
    always_comb begin
        cond = 1'b0;
        case (E_ifun)
            C_YES:   cond = 1'b1;
            C_LE:    cond = (sf ^ of) | zf;
            C_L:     cond = sf ^ of;
            C_E:     cond = zf;
            C_NE:    cond = !zf;
            C_GE:    cond = !(sf ^ of);
            C_G:     cond = !(sf ^ of) && !zf;
            default: cond = 1'b0;
        endcase
    end

    assign e_cnd  = ((E_icode == I_RRMOVQ) || (E_icode == I_JXX)) ? cond : 1'b0;
    assign e_dstE = ((E_icode == I_RRMOVQ) && !e_cnd) ? RNONE : E_dstE;

    // Bubble outranks stall so a stalled, squashed slot still becomes a NOP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            M_icode <= I_NOP;
            M_cnd   <= 1'b0;
            M_valE  <= '0;
            M_valA  <= '0;
            M_dstE  <= RNONE;
            M_dstM  <= RNONE;
        end else if (M_bubble) begin
            M_icode <= I_NOP;
            M_cnd   <= 1'b0;
            M_valE  <= '0;
            M_valA  <= '0;
            M_dstE  <= RNONE;
            M_dstM  <= RNONE;
        end else if (!M_stall) begin
            M_icode <= E_icode;
            M_cnd   <= e_cnd;
            M_valE  <= alu_valE;
            M_valA  <= E_valA;
            M_dstE  <= e_dstE;
            M_dstM  <= E_dstM;
        end
    end

endmodule

// File: tb/tb_exec_cc_unit.sv
// Self-checking bench for exec_cc_unit: condition sweep table plus
// hand-written CC latency, exception, cmov and stall/bubble sequences.
module tb_exec_cc_unit;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [3:0]   E_icode = 4'h1;
    logic [3:0]   E_ifun = 4'h0;
    logic [W-1:0] alu_valE = '0;
    logic [2:0]   alu_cc = 3'b000;
    logic [W-1:0] E_valA = '0;
    logic [3:0]   E_dstE = 4'hF;
    logic [3:0]   E_dstM = 4'hF;
    logic         m_stat_bad = 1'b0;
    logic         W_stat_bad = 1'b0;
    logic         M_stall = 1'b0;
    logic         M_bubble = 1'b0;
    logic         e_cnd;
    logic [3:0]   e_dstE;
    logic [2:0]   cc_q;
    logic [3:0]   M_icode;
    logic         M_cnd;
    logic [W-1:0] M_valE;
    logic [W-1:0] M_valA;
    logic [3:0]   M_dstE;
    logic [3:0]   M_dstM;

    exec_cc_unit #(.W(W), .CC_RESET(3'b100), .RNONE(4'hF)) dut (
        .clk(clk), .reset(reset),
        .E_icode(E_icode), .E_ifun(E_ifun), .alu_valE(alu_valE), .alu_cc(alu_cc),
        .E_valA(E_valA), .E_dstE(E_dstE), .E_dstM(E_dstM),
        .m_stat_bad(m_stat_bad), .W_stat_bad(W_stat_bad),
        .M_stall(M_stall), .M_bubble(M_bubble),
        .e_cnd(e_cnd), .e_dstE(e_dstE), .cc_q(cc_q),
        .M_icode(M_icode), .M_cnd(M_cnd), .M_valE(M_valE), .M_valA(M_valA),
        .M_dstE(M_dstE), .M_dstM(M_dstM)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   icode;
        logic         cnd;
        logic [W-1:0] valE;
        logic [W-1:0] valA;
        logic [3:0]   dstE;
        logic [3:0]   dstM;
    } m_t;

    typedef struct {
        logic [2:0] cc;
        logic [3:0] icode;
        logic [3:0] ifun;
        logic [3:0] dste;
        logic       exp_cnd;
        logic [3:0] exp_dste;
    } vec_t;

    localparam m_t M_NOP = '{icode: 4'h1, cnd: 1'b0, valE: '0, valA: '0, dstE: 4'hF, dstM: 4'hF};

    int n_checks = 0;
    int n_fail   = 0;

    // Truth table per ifun, bit index = {Z,S,O}.
    logic [7:0] cmask [16];
    logic [2:0] m_cc;
    m_t         m_exp;
    m_t         sb [$];
    vec_t       vecs [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_cnd(input logic [3:0] icode, input logic [3:0] ifun,
                                       input logic [2:0] cc);
        logic [7:0] m;
        m = cmask[ifun];
        return ((icode == 4'h2) || (icode == 4'h7)) ? m[cc] : 1'b0;
    endfunction

    // Push the expected M contents for this edge, clock, then pop and compare.
    task automatic tick();
        m_t   nxt;
        m_t   got;
        logic c;
        c = model_cnd(E_icode, E_ifun, m_cc);
        if (M_bubble) nxt = M_NOP;
        else if (M_stall) nxt = m_exp;
        else begin
            nxt.icode = E_icode;
            nxt.cnd   = c;
            nxt.valE  = alu_valE;
            nxt.valA  = E_valA;
            nxt.dstE  = (E_icode == 4'h2 && !c) ? 4'hF : E_dstE;
            nxt.dstM  = E_dstM;
        end
        sb.push_back(nxt);
        @(posedge clk);
        if (E_icode == 4'h6 && !m_stat_bad && !W_stat_bad) m_cc = alu_cc;
        m_exp = nxt;
        #1;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty at %0t", $time);
        end else begin
            got = sb.pop_front();
            check("M_icode", 64'(M_icode), 64'(got.icode));
            check("M_cnd",   64'(M_cnd),   64'(got.cnd));
            check("M_valE",  M_valE,       got.valE);
            check("M_valA",  M_valA,       got.valA);
            check("M_dstE",  64'(M_dstE),  64'(got.dstE));
            check("M_dstM",  64'(M_dstM),  64'(got.dstM));
        end
        check("cc_q", 64'(cc_q), 64'(m_cc));
    endtask

    task automatic drive(input logic [3:0] icode, input logic [3:0] ifun, input logic [2:0] acc,
                         input logic [3:0] dste);
        E_icode    = icode;
        E_ifun     = ifun;
        alu_cc     = acc;
        E_dstE     = dste;
        E_dstM     = 4'($urandom_range(0, 15));
        alu_valE   = {$urandom, $urandom};
        E_valA     = {$urandom, $urandom};
        m_stat_bad = 1'b0;
        W_stat_bad = 1'b0;
        M_stall    = 1'b0;
        M_bubble   = 1'b0;
    endtask

    task automatic load_cc(input logic [2:0] c);
        drive(4'h6, 4'h0, c, 4'h5);
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        m_cc = 3'b100;
        m_exp = M_NOP;
        sb.delete();
        check("rst_cc_q",    64'(cc_q),    64'(3'b100));
        check("rst_M_icode", 64'(M_icode), 64'h1);
        check("rst_M_cnd",   64'(M_cnd),   64'h0);
        check("rst_M_valE",  M_valE,       64'h0);
        check("rst_M_valA",  M_valA,       64'h0);
        check("rst_M_dstE",  64'(M_dstE),  64'hF);
        check("rst_M_dstM",  64'(M_dstM),  64'hF);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        cmask[0] = 8'hFF; cmask[1] = 8'hF6; cmask[2] = 8'h66; cmask[3] = 8'hF0;
        cmask[4] = 8'h0F; cmask[5] = 8'h99; cmask[6] = 8'h09;
        for (int i = 7; i < 16; i++) cmask[i] = 8'h00;

        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 16; f++) begin
                vec_t v;
                logic [7:0] m;
                m = cmask[f];
                v.cc = 3'(c); v.icode = 4'h7; v.ifun = 4'(f); v.dste = 4'hF;
                v.exp_cnd = m[c]; v.exp_dste = 4'hF;
                vecs.push_back(v);
            end
            for (int f = 0; f < 8; f++) begin
                vec_t v;
                logic [7:0] m;
                m = cmask[f];
                v.cc = 3'(c); v.icode = 4'h2; v.ifun = 4'(f); v.dste = 4'(c + 1);
                v.exp_cnd = m[c]; v.exp_dste = m[c] ? 4'(c + 1) : 4'hF;
                vecs.push_back(v);
            end
            vecs.push_back('{cc: 3'(c), icode: 4'h6, ifun: 4'h3, dste: 4'h4,
                             exp_cnd: 1'b0, exp_dste: 4'h4});
        end

        // Reset asserted between clock edges, checked before any edge.
        #2;
        do_reset();
        @(negedge clk);
        drive(4'h7, 4'h3, 3'b000, 4'hF);
        #1;
        check("post_rst_je", 64'(e_cnd), 64'h1);
        tick();

        // CC latency: flags of an OPq are not visible until after its edge.
        drive(4'h7, 4'h1, 3'b010, 4'hF);
        #1;
        check("jle_old_cc", 64'(e_cnd), 64'h1);
        drive(4'h6, 4'h0, 3'b010, 4'h2);
        #1;
        check("opq_cc_not_yet", 64'(cc_q), 64'(3'b100));
        tick();
        check("opq_cc_now", 64'(cc_q), 64'(3'b010));
        drive(4'h7, 4'h2, 3'b000, 4'hF);
        #1;
        check("jl_new_cc", 64'(e_cnd), 64'h1);
        drive(4'h7, 4'h6, 3'b000, 4'hF);
        #1;
        check("jg_new_cc", 64'(e_cnd), 64'h0);
        tick();

        // Exception suppression of the CC write.
        drive(4'h6, 4'h0, 3'b001, 4'h2);
        m_stat_bad = 1'b1;
        tick();
        check("cc_m_bad", 64'(cc_q), 64'(3'b010));
        drive(4'h6, 4'h0, 3'b001, 4'h2);
        W_stat_bad = 1'b1;
        tick();
        check("cc_w_bad", 64'(cc_q), 64'(3'b010));
        drive(4'h6, 4'h0, 3'b001, 4'h2);
        tick();
        check("cc_no_bad", 64'(cc_q), 64'(3'b001));

        // cmov cancel.
        load_cc(3'b000);
        drive(4'h2, 4'h3, 3'b000, 4'h3);
        #1;
        check("cmove_cnd", 64'(e_cnd), 64'h0);
        check("cmove_dstE", 64'(e_dstE), 64'hF);
        tick();
        check("cmove_M_dstE", 64'(M_dstE), 64'hF);
        check("cmove_M_cnd", 64'(M_cnd), 64'h0);
        drive(4'h2, 4'h4, 3'b000, 4'h3);
        #1;
        check("cmovne_dstE", 64'(e_dstE), 64'h3);
        tick();

        // Stall holds, bubble overrides stall.
        drive(4'h0, 4'h0, 3'b000, 4'h7);
        alu_valE = 64'hDEADBEEF;
        tick();
        drive(4'h3, 4'h0, 3'b000, 4'h8);
        M_stall = 1'b1;
        tick();
        check("stall_valE", M_valE, 64'hDEADBEEF);
        drive(4'h3, 4'h0, 3'b000, 4'h8);
        M_stall = 1'b1;
        M_bubble = 1'b1;
        tick();
        check("bubble_icode", 64'(M_icode), 64'h1);
        check("bubble_valE", M_valE, 64'h0);
        check("bubble_dstE", 64'(M_dstE), 64'hF);

        // Condition sweep table.
        foreach (vecs[i]) begin
            if (m_cc != vecs[i].cc) load_cc(vecs[i].cc);
            drive(vecs[i].icode, vecs[i].ifun, vecs[i].cc, vecs[i].dste);
            #1;
            check($sformatf("sweep_cnd[%0d]", i), 64'(e_cnd), 64'(vecs[i].exp_cnd));
            check($sformatf("sweep_dstE[%0d]", i), 64'(e_dstE), 64'(vecs[i].exp_dste));
            tick();
        end

        // Reset again mid-cycle after the state has been disturbed.
        load_cc(3'b011);
        drive(4'h2, 4'h0, 3'b000, 4'h9);
        tick();
        #1;
        do_reset();
        drive(4'h7, 4'h3, 3'b000, 4'hF);
        #1;
        check("rst2_je", 64'(e_cnd), 64'h1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/exec_cc_unit.md
Name: exec_cc_unit

Overview:
- Consumer end of the ALU result/condition-code path in the Y86 execute stage.
- Takes the ALU mux outputs (64-bit valE, 3-bit CC), holds the architectural condition-code register, and evaluates branch/cmov conditions from it.
- Contains the E->M pipeline register with stall/bubble control, and cancels the cmov destination when the condition fails.

Parameters:
W, 64, datapath width of valE/valA.
CC_RESET, 3'b100, CC register reset value {ZF,SF,OF}: ZF=1, SF=0, OF=0.
RNONE, 4'hF, register ID meaning "no destination".

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
E_icode  in  4  execute-stage instruction code
E_ifun  in  4  execute-stage function code (ALU op or condition)
alu_valE  in  W  ALU result from mux
alu_cc  in  3  ALU-computed flags {ZF,SF,OF} = bits [2],[1],[0]
E_valA  in  W  operand passed to memory stage
E_dstE  in  4  E-port destination register ID
E_dstM  in  4  M-port destination register ID
m_stat_bad  in  1  memory stage currently holds an exception
W_stat_bad  in  1  writeback stage currently holds an exception
M_stall  in  1  hold the M register
M_bubble  in  1  inject a NOP into the M register
e_cnd  out  1  combinational condition result for the current E instruction
e_dstE  out  4  combinational dstE after cmov cancel, for forwarding
cc_q  out  3  current CC register contents
M_icode  out  4  registered icode
M_cnd  out  1  registered e_cnd
M_valE  out  W  registered alu_valE
M_valA  out  W  registered E_valA
M_dstE  out  4  registered e_dstE
M_dstM  out  4  registered E_dstM

Behaviour:
- **Reset:** asynchronous; takes effect immediately, mid-instruction included. Reset values:
  - cc_q = CC_RESET.
  - M_icode = 4'h1 (NOP), M_cnd = 0, M_valE = 0, M_valA = 0, M_dstE = RNONE, M_dstM = RNONE.
- **CC write enable:** set_cc = (E_icode == 4'h6 OPq) && !m_stat_bad && !W_stat_bad.
  - On a clk rise with set_cc: cc_q <= alu_cc.
  - Otherwise cc_q holds.
  - The CC update ignores M_stall and M_bubble.
- **CC timing:** e_cnd always uses the current cc_q, never alu_cc. An OPq's flags are visible to the next instruction (1-cycle latency), not to itself.
- **Condition evaluation:** with Z, S, O = cc_q[2], cc_q[1], cc_q[0], the condition by E_ifun is:
  - 0 always: 1
  - 1 le: (S^O)|Z
  - 2 l: S^O
  - 3 e: Z
  - 4 ne: !Z
  - 5 ge: !(S^O)
  - 6 g: !(S^O)&!Z
  - 7..F: 0
- **e_cnd gating:** e_cnd = condition when E_icode is 4'h2 (rrmovq/cmovXX) or 4'h7 (jXX); otherwise 0.
- **cmov cancel:** e_dstE = RNONE when E_icode == 4'h2 and e_cnd == 0; otherwise E_dstE.
- **M register, on each clk rise (priority order):**
  1. M_bubble = 1: load the reset (NOP) values. Bubble wins over stall.
  2. Else M_stall = 1: all M_* outputs hold.
  3. Else load E_icode, e_cnd, alu_valE, E_valA, e_dstE, E_dstM.
- **Datapath:** no arithmetic inside the block; values pass through at full width unchanged.
- **Unused codes:** ifun codes above 6 never assert e_cnd; nothing is flagged.

Test Plan:
1. **Reset:** assert reset mid-cycle with no clock edge. cc_q = 3'b100 and M_icode = 1, M_dstE = F, M_dstM = F immediately. After release, E_icode = 7, E_ifun = 3 (je) gives e_cnd = 1.
2. **CC latency:** OPq with alu_cc = 3'b010 (SF) at edge N. At cycle N, jle (7/1) still sees the old CC, so e_cnd = 1 via ZF=1. After edge N, cc_q = 3'b010; jl (7/2) gives e_cnd = 1 and jg (7/6) gives e_cnd = 0.
3. **Exception suppression:** OPq with alu_cc = 3'b001 and m_stat_bad = 1 -> cc_q unchanged after the edge. Repeat with W_stat_bad = 1 -> unchanged. Repeat with both 0 -> cc_q = 3'b001.
4. **cmov cancel:** cc_q = 3'b000, E_icode = 2, E_ifun = 3 (cmove), E_dstE = 4'h3. Expect e_cnd = 0, e_dstE = F, and after the edge M_dstE = F, M_cnd = 0. With E_ifun = 4 (cmovne): e_dstE = 3.
5. **Stall/bubble:** load alu_valE = 64'hDEADBEEF, then M_stall = 1 with new inputs -> M_valE stays DEADBEEF. Assert M_stall and M_bubble together -> M_icode = 1, M_valE = 0, M_dstE = F.
6. **Sweep:** all 8 CC values × ifun 0..F with E_icode = 7 -> e_cnd matches the condition table, and is 0 for ifun ≥ 7. With E_icode = 6 -> e_cnd = 0.
